// File: rtl/nn_pkg.sv
// Shared types and default sizing for the neural-network calculation sequencer.
package nn_pkg;

    localparam int DEFAULT_NUM_IN  = 784;
    localparam int DEFAULT_NUM_OUT = 10;

    localparam int PIXEL_AW  = 10;
    localparam int WEIGHT_AW = 13;
    localparam int OUT_AW    = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after reaching rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= (count_out == rollover_val) ? '0 : count_out + 1'b1;
        end
    end

endmodule

// File: rtl/nn_calc_sequencer.sv
// Sequences pixel/weight reads and MAC/result-register control for a fully
// connected layer: one neuron at a time, NUM_IN products per neuron.
module nn_calc_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_IN  = DEFAULT_NUM_IN,
    parameter int NUM_OUT = DEFAULT_NUM_OUT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_calc,
    input  logic                 abort,
    output logic [PIXEL_AW-1:0]  pixel_raddr,
    output logic [WEIGHT_AW-1:0] weight_raddr,
    output logic                 mac_clear,
    output logic                 mac_en,
    output logic                 result_we,
    output logic [OUT_AW-1:0]    output_address,
    output logic                 busy,
    output logic                 done_calc
);

    localparam logic [PIXEL_AW-1:0] LAST_IDX    = PIXEL_AW'(NUM_IN - 1);
    localparam logic [OUT_AW-1:0]   LAST_NEURON = OUT_AW'(NUM_OUT - 1);

    state_t               state;
    state_t               next_state;
    logic [PIXEL_AW-1:0]  idx;
    logic [WEIGHT_AW-1:0] weight_ptr;
    logic [OUT_AW-1:0]    neuron;
    logic                 start_run;
    logic                 issue;

    assign start_run = (state == IDLE) && start_calc && !abort;

    // Addresses are registered, so they are loaded on the edge that enters
    // or stays in ACCUM; idx and weight_ptr always hold the next operand.
    assign issue = (next_state == ACCUM);

    flex_counter #(
        .NUM_CNT_BITS(PIXEL_AW)
    ) u_idx (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (start_run),
        .count_enable (issue),
        .rollover_val (LAST_IDX),
        .count_out    (idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_calc) next_state = CLEAR;
            CLEAR:   next_state = ACCUM;
            ACCUM:   if (pixel_raddr == LAST_IDX) next_state = DRAIN;
            DRAIN:   next_state = STORE;
            STORE:   next_state = (neuron == LAST_NEURON) ? DONE : CLEAR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pixel_raddr    <= '0;
            weight_raddr   <= '0;
            weight_ptr     <= '0;
            neuron         <= '0;
            output_address <= '0;
            mac_clear      <= 1'b0;
            mac_en         <= 1'b0;
            result_we      <= 1'b0;
            busy           <= 1'b0;
            done_calc      <= 1'b0;
        end else begin
            busy      <= (next_state != IDLE);
            mac_clear <= (next_state == CLEAR);
            result_we <= (next_state == STORE);
            done_calc <= (next_state == DONE);
            // Read data for an address issued in ACCUM arrives one cycle later.
            mac_en    <= (state == ACCUM) && !abort;

            if (start_run) begin
                neuron       <= '0;
                weight_ptr   <= '0;
                weight_raddr <= '0;
            end

            if (issue) begin
                pixel_raddr  <= idx;
                weight_raddr <= weight_ptr;
                weight_ptr   <= weight_ptr + 1'b1;
            end

            if (next_state == STORE) output_address <= neuron;

            if ((state == STORE) && (next_state == CLEAR)) neuron <= neuron + 1'b1;
        end
    end

endmodule
